sprite_anim: RTL and testbench
==============================

# sprite_anim

Scan-line sprite engine with animation frames, horizontal/vertical mirroring, integer power-of-two scaling on both axes and colour-key transparency. It is the parametrised successor to the single-frame sprite engine. It sits between the display timing generator (sx, sy, line) and the pixel mixer. It reads a synchronous, one-cycle-latency sprite ROM that holds SPR_FRAMES bitmaps stored back to back.

## Interface
- CORDW, 10: screen coordinate width (unsigned)
- H_RES, 784: horizontal resolution in pixels
- SX_OFFS, 2: horizontal pipeline lead in pixels; must be 2
- SPR_WIDTH, 8: bitmap width in pixels
- SPR_HEIGHT, 8: bitmap height in pixels
- SPR_FRAMES, 4: number of animation frames in ROM
- SPR_SCALE, 0: log2 of the scale factor, applied to both axes
- SPR_DATAW, 3: bits per pixel
- TRANSP_EN, 1: enables colour-key transparency
- TRANSP_COLOR, 0: colour-key value
- ADDRW = $clog2(SPR_FRAMES*SPR_WIDTH*SPR_HEIGHT); derived, not overridable
- FRW = $clog2(SPR_FRAMES); derived, not overridable

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  sprite enable; sampled only on line
- line  in  1  one-cycle pulse marking the start of a screen line
- sx, sy  in  CORDW  current screen position
- sprx, spry  in  CORDW  sprite top-left position
- frame  in  FRW  animation frame index
- hflip, vflip  in  1  mirror controls
- spr_rom_data  in  SPR_DATAW  ROM data; valid one cycle after spr_rom_addr
- spr_rom_addr  out  ADDRW  ROM address, registered
- pix  out  SPR_DATAW  pixel colour, registered
- drawing  out  1  pix is an opaque sprite pixel
- state  out  3  FSM state, for debug

## Operation
- States, with encodings:
  - IDLE=0, REG_POS=1, ACTIVE=2, WAIT_POS=3, FETCH=4, DRAW=5, WAIT_DATA=6.
  - Any other encoding goes to IDLE.
- Priority: rst > line > normal FSM.
- On line:
  - If en=1, go to REG_POS; if en=0, go to IDLE.
  - Clear pix, drawing and spr_rom_addr.
- REG_POS: latch sprx, spry, frame, hflip and vflip into shadow registers, then go to ACTIVE. Changing these inputs mid-line has no effect until the next line.
- ACTIVE:
  - diff = sy − spry_r, computed as a signed CORDW+1-bit value.
  - row = diff >>> SPR_SCALE.
  - If 0 ≤ row < SPR_HEIGHT, go to WAIT_POS; otherwise go to IDLE.
- WAIT_POS, when sx + SX_OFFS == sprx_r (CORDW+1-bit compare):
  - Issue the column-0 address, clear the column counter and scale counter, and go to FETCH.
  - Sprites with sprx < SX_OFFS are not drawn.
- Address for bitmap column c:
  - frame_r·W·H + r'·W + c', where r' = vflip_r ? H−1−row : row and c' = hflip_r ? W−1−c : c.
  - Computed in ADDRW bits. A frame_r ≥ SPR_FRAMES gives an undefined image but a legal address.
- FETCH: one cycle for ROM latency, then go to DRAW.
- DRAW:
  - pix ← spr_rom_data.
  - drawing ← 1, except drawing ← 0 and pix ← 0 when TRANSP_EN=1 and the data equals TRANSP_COLOR.
  - Each bitmap column is held for exactly 2^SPR_SCALE cycles.
  - The address advances so that the next column's data arrives exactly when needed.
  - After the last scale cycle of column W−1, go to WAIT_DATA.
- Line-end clip: sx == H_RES − SX_OFFS while in FETCH or DRAW forces WAIT_DATA.
- WAIT_DATA: pix ← 0, drawing ← 0, spr_rom_addr ← 0, then go to IDLE.
- IDLE: hold until line.

## Timing
- Reset values: state=IDLE, spr_rom_addr=0, pix=0, drawing=0, and all internal counters and shadow registers 0. Assertion takes effect immediately, without a clock.
- rst asserted mid-line: outputs clear asynchronously. After release the engine stays IDLE until the next line.
- Latency from line to REG_POS: 1 cycle.
- First sprite pixel: pix/drawing for screen column sprx+k is visible during the cycle in which sx == sprx+k+1. This is a fixed one-cycle output lag; the mixer compensates.
- Output window: exactly W·2^SPR_SCALE consecutive cycles with pix sourced from the ROM. drawing is low in the first cycle after the window.
- line arriving during DRAW: it wins. Drawing drops in the next cycle and a new line sequence starts.
- Vertical scale: screen rows spry .. spry + H·2^SPR_SCALE − 1 are drawn.

## Test plan
- W=H=8, FRAMES=4, S=0; sprx=100, spry=50, sy=50, frame=2, no flips:
  - first spr_rom_addr = 128, issued at sx=98;
  - drawing high for sx=101..108 (8 cycles);
  - addresses 128..135.
- Same setup with hflip=1, vflip=1, sy=50: addresses run 191 down to 184.
- S=1, sy=53 (row 1), frame=0:
  - each column is held for 2 cycles, 16 drawing cycles;
  - addresses 8..15;
  - sy=66 → row 8 → no drawing, and the FSM goes ACTIVE→IDLE.
- TRANSP_EN=1, colour key 0, ROM row pattern 0,5,0,5,…: drawing alternates 0,1,0,1 with pix 0,5,0,5.
- Clip at line end: sprx=H_RES−4, S=0, sx sweeps to the end → WAIT_DATA entered at sx=H_RES−2 and drawing low on the next cycle.
- Reset and enable:
  - rst pulsed while drawing → pix=0, drawing=0 and state=0 immediately;
  - no drawing until the next line;
  - en=0 at line → no ROM activity for that line.

Source files
------------

// File: rtl/sprite_anim.sv
// sprite_anim: scan-line sprite engine with animation frames, h/v mirroring,
// power-of-two scaling and colour-key transparency. Fetches one bitmap row per
// screen line from a synchronous one-cycle-latency ROM and emits registered
// pixels one cycle behind the screen column they belong to.
module sprite_anim #(
   parameter  int CORDW        = 10,
   parameter  int H_RES        = 784,
   parameter  int SX_OFFS      = 2,
   parameter  int SPR_WIDTH    = 8,
   parameter  int SPR_HEIGHT   = 8,
   parameter  int SPR_FRAMES   = 4,
   parameter  int SPR_SCALE    = 0,
   parameter  int SPR_DATAW    = 3,
   parameter  int TRANSP_EN    = 1,
   parameter  int TRANSP_COLOR = 0,
   localparam int ADDRW        = $clog2(SPR_FRAMES*SPR_WIDTH*SPR_HEIGHT),
   localparam int FRW          = $clog2(SPR_FRAMES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 line,
   input  logic [CORDW-1:0]     sx,
   input  logic [CORDW-1:0]     sy,
   input  logic [CORDW-1:0]     sprx,
   input  logic [CORDW-1:0]     spry,
   input  logic [FRW-1:0]       frame,
   input  logic                 hflip,
   input  logic                 vflip,
   input  logic [SPR_DATAW-1:0] spr_rom_data,
   output logic [ADDRW-1:0]     spr_rom_addr,
   output logic [SPR_DATAW-1:0] pix,
   output logic                 drawing,
   output logic [2:0]           state
);

   localparam int CW = $clog2(SPR_WIDTH + 1);
   localparam int RW = (SPR_HEIGHT > 1) ? $clog2(SPR_HEIGHT) : 1;
   localparam int SW = (SPR_SCALE > 0) ? SPR_SCALE : 1;
   localparam int DW = CORDW + 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      REG_POS   = 3'd1,
      ACTIVE    = 3'd2,
      WAIT_POS  = 3'd3,
      FETCH     = 3'd4,
      DRAW      = 3'd5,
      WAIT_DATA = 3'd6
   } state_t;

   state_t            state_reg;
   logic [CORDW-1:0]  sprx_reg, spry_reg;
   logic [FRW-1:0]    frame_reg;
   logic              hflip_reg, vflip_reg;
   logic [ADDRW-1:0]  base_reg;   // frame and row part of the ROM address
   logic [CW-1:0]     col_reg;    // column whose address is currently on the ROM bus
   logic [SW-1:0]     scl_reg;    // repeat count within that column

   logic signed [DW-1:0] diff, row;
   logic                 row_ok;
   logic [RW-1:0]        row_idx, row_eff;
   logic [ADDRW-1:0]     base_next, col0_addr, next_addr;
   logic [CW-1:0]        col_inc;
   logic                 at_pos, scl_last, clip, transparent, col_done;

   assign state = state_reg;

   // Row selection, address arithmetic and trigger conditions.
   always_comb begin
      diff      = $signed({1'b0, sy}) - $signed({1'b0, spry_reg});
      row       = diff >>> SPR_SCALE;
      row_ok    = !row[DW-1] && (row[DW-2:0] < (DW-1)'(SPR_HEIGHT));
      row_idx   = row[RW-1:0];
      row_eff   = vflip_reg ? (RW'(SPR_HEIGHT - 1) - row_idx) : row_idx;
      base_next = ADDRW'(frame_reg) * ADDRW'(SPR_WIDTH * SPR_HEIGHT)
                + ADDRW'(row_eff) * ADDRW'(SPR_WIDTH);
      col0_addr = base_reg + (hflip_reg ? ADDRW'(SPR_WIDTH - 1) : '0);
      col_inc   = col_reg + CW'(1);
      next_addr = base_reg + (hflip_reg ? (ADDRW'(SPR_WIDTH - 1) - ADDRW'(col_inc))
                                        : ADDRW'(col_inc));
      col_done  = (col_reg == CW'(SPR_WIDTH));
      at_pos    = (({1'b0, sx} + DW'(SX_OFFS)) == {1'b0, sprx_reg});
      scl_last  = (SPR_SCALE == 0) || (scl_reg == SW'((1 << SPR_SCALE) - 1));
      clip      = (sx == CORDW'(H_RES - SX_OFFS));
      transparent = (TRANSP_EN != 0) && (spr_rom_data == SPR_DATAW'(TRANSP_COLOR));
   end

   // Line FSM: the address stream runs one cycle ahead of the drawn column,
   // so the last draw cycle is the one where col_reg has stepped past W-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         sprx_reg     <= '0;
         spry_reg     <= '0;
         frame_reg    <= '0;
         hflip_reg    <= 1'b0;
         vflip_reg    <= 1'b0;
         base_reg     <= '0;
         col_reg      <= '0;
         scl_reg      <= '0;
         spr_rom_addr <= '0;
         pix          <= '0;
         drawing      <= 1'b0;
      end else if (line) begin
         state_reg    <= en ? REG_POS : IDLE;
         spr_rom_addr <= '0;
         pix          <= '0;
         drawing      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: state_reg <= IDLE;
            REG_POS: begin
               sprx_reg  <= sprx;
               spry_reg  <= spry;
               frame_reg <= frame;
               hflip_reg <= hflip;
               vflip_reg <= vflip;
               state_reg <= ACTIVE;
            end
            ACTIVE: begin
               if (row_ok) begin
                  base_reg  <= base_next;
                  state_reg <= WAIT_POS;
               end else begin
                  state_reg <= IDLE;
               end
            end
            WAIT_POS: begin
               if (at_pos) begin
                  spr_rom_addr <= col0_addr;
                  col_reg      <= '0;
                  scl_reg      <= '0;
                  state_reg    <= FETCH;
               end
            end
            FETCH, DRAW: begin
               if (state_reg == DRAW) begin
                  pix     <= transparent ? '0 : spr_rom_data;
                  drawing <= !transparent;
               end
               if (clip || (state_reg == DRAW && col_done))
                  state_reg <= WAIT_DATA;
               else if (state_reg == FETCH)
                  state_reg <= DRAW;
               if (!col_done) begin
                  if (scl_last) begin
                     col_reg <= col_inc;
                     scl_reg <= '0;
                     if (col_inc != CW'(SPR_WIDTH))
                        spr_rom_addr <= next_addr;
                  end else begin
                     scl_reg <= scl_reg + SW'(1);
                  end
               end
            end
            WAIT_DATA: begin
               pix          <= '0;
               drawing      <= 1'b0;
               spr_rom_addr <= '0;
               state_reg    <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_anim.sv
// Bench for sprite_anim: two instances (scale 0 and scale 1) share the timing
// inputs; each has its own ROM model. Outputs are logged per screen column.
module tb_sprite_anim;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, line = 1'b0, hflip = 1'b0, vflip = 1'b0;
   logic [9:0] sx = '0, sy = '0, sprx = '0, spry = '0;
   logic [1:0] frame = '0;
   logic [2:0] q0, q1, pix0, pix1, st0, st1;
   logic [7:0] ad0, ad1;
   logic       dr0, dr1;

   logic [2:0] rom [256];
   logic [2:0] st0_log [1024], st1_log [1024], px0_log [1024], px1_log [1024];
   logic [7:0] ad0_log [1024], ad1_log [1024];
   logic       dr0_log [1024], dr1_log [1024];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sprite_anim #(.SPR_SCALE(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .line(line), .sx(sx), .sy(sy),
      .sprx(sprx), .spry(spry), .frame(frame), .hflip(hflip), .vflip(vflip),
      .spr_rom_data(q0), .spr_rom_addr(ad0), .pix(pix0), .drawing(dr0), .state(st0));

   sprite_anim #(.SPR_SCALE(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .line(line), .sx(sx), .sy(sy),
      .sprx(sprx), .spry(spry), .frame(frame), .hflip(hflip), .vflip(vflip),
      .spr_rom_data(q1), .spr_rom_addr(ad1), .pix(pix1), .drawing(dr1), .state(st1));

   // Synchronous ROM models, one-cycle latency.
   always @(posedge clk) begin
      q0 <= rom[ad0];
      q1 <= rom[ad1];
   end

   // Frame 0 row 0 is 0,5,0,5,...; every other word is non-zero.
   function automatic logic [2:0] rv(input int a);
      if (a < 8) return (a % 2 == 1) ? 3'd5 : 3'd0;
      return 3'((a % 7) + 1);
   endfunction

   // Wait for the next edge, log the outputs seen during column x, then drive x.
   task automatic step(input int x, input logic ln);
      @(posedge clk); #1;
      st0_log[x] = st0; st1_log[x] = st1;
      px0_log[x] = pix0; px1_log[x] = pix1;
      ad0_log[x] = ad0; ad1_log[x] = ad1;
      dr0_log[x] = dr0; dr1_log[x] = dr1;
      sx = 10'(x); line = ln;
   endtask

   task automatic run_line(input int yy, input int nsx);
      for (int i = 0; i < 1024; i++) begin
         st0_log[i] = 'x; st1_log[i] = 'x; px0_log[i] = 'x; px1_log[i] = 'x;
         ad0_log[i] = 'x; ad1_log[i] = 'x; dr0_log[i] = 'x; dr1_log[i] = 'x;
      end
      sy = 10'(yy);
      step(0, 1'b1);
      for (int x = 1; x < nsx; x++) step(x, 1'b0);
   endtask

   task automatic setup(input int px, input int py, input int fr,
                        input logic hf, input logic vf);
      sprx = 10'(px); spry = 10'(py); frame = 2'(fr); hflip = hf; vflip = vf; en = 1'b1;
   endtask

   task automatic test_reset;
      @(posedge clk); #1;
      n_tests++;
      if ({st0, ad0, pix0, dr0} !== 15'd0) begin
         n_fail++; $display("FAIL reset_dut0: got st=%0d addr=%0d pix=%0d drw=%0d required all 0", st0, ad0, pix0, dr0);
      end
      n_tests++;
      if ({st1, ad1, pix1, dr1} !== 15'd0) begin
         n_fail++; $display("FAIL reset_dut1: got st=%0d addr=%0d pix=%0d drw=%0d required all 0", st1, ad1, pix1, dr1);
      end
      rst = 1'b0;
      $display("[TB] reset checked");
   endtask

   task automatic test_basic;
      setup(100, 50, 2, 1'b0, 1'b0);
      run_line(50, 130);
      n_tests++;
      if (st0_log[1] !== 3'd1) begin n_fail++; $display("FAIL basic_regpos: got %0d required 1", st0_log[1]); end
      n_tests++;
      if (st0_log[98] !== 3'd3) begin n_fail++; $display("FAIL basic_waitpos98: got %0d required 3", st0_log[98]); end
      n_tests++;
      if (st0_log[99] !== 3'd4) begin n_fail++; $display("FAIL basic_fetch99: got %0d required 4", st0_log[99]); end
      for (int k = 0; k < 8; k++) begin
         n_tests++;
         if (ad0_log[99+k] !== 8'(128 + k)) begin
            n_fail++; $display("FAIL basic_addr[%0d]: got %0d required %0d", k, ad0_log[99+k], 128 + k);
         end
         n_tests++;
         if (dr0_log[101+k] !== 1'b1 || px0_log[101+k] !== rv(128 + k)) begin
            n_fail++; $display("FAIL basic_pix[%0d]: got drw=%0d pix=%0d required drw=1 pix=%0d", k, dr0_log[101+k], px0_log[101+k], rv(128 + k));
         end
      end
      n_tests++;
      if (dr0_log[100] !== 1'b0 || dr0_log[109] !== 1'b0) begin
         n_fail++; $display("FAIL basic_window_edges: got drw100=%0d drw109=%0d required 0 0", dr0_log[100], dr0_log[109]);
      end
      n_tests++;
      if (st0_log[108] !== 3'd6 || st0_log[109] !== 3'd0) begin
         n_fail++; $display("FAIL basic_end_states: got %0d %0d required 6 0", st0_log[108], st0_log[109]);
      end
      $display("[TB] basic line checked");
   endtask

   task automatic test_flip;
      setup(100, 50, 2, 1'b1, 1'b1);
      run_line(50, 130);
      for (int k = 0; k < 8; k++) begin
         n_tests++;
         if (ad0_log[99+k] !== 8'(191 - k) || px0_log[101+k] !== rv(191 - k)) begin
            n_fail++; $display("FAIL flip[%0d]: got addr=%0d pix=%0d required addr=%0d pix=%0d", k, ad0_log[99+k], px0_log[101+k], 191 - k, rv(191 - k));
         end
      end
      $display("[TB] flipped line checked");
   endtask

   task automatic test_scale;
      setup(100, 50, 0, 1'b0, 1'b0);
      run_line(53, 130);
      for (int j = 0; j < 16; j++) begin
         n_tests++;
         if (ad1_log[99+j] !== 8'(8 + j/2) || dr1_log[101+j] !== 1'b1 || px1_log[101+j] !== rv(8 + j/2)) begin
            n_fail++; $display("FAIL scale[%0d]: got addr=%0d drw=%0d pix=%0d required addr=%0d drw=1 pix=%0d", j, ad1_log[99+j], dr1_log[101+j], px1_log[101+j], 8 + j/2, rv(8 + j/2));
         end
      end
      n_tests++;
      if (dr1_log[100] !== 1'b0 || dr1_log[117] !== 1'b0) begin
         n_fail++; $display("FAIL scale_window_edges: got drw100=%0d drw117=%0d required 0 0", dr1_log[100], dr1_log[117]);
      end
      run_line(65, 8);
      n_tests++;
      if (st1_log[3] !== 3'd3) begin n_fail++; $display("FAIL scale_row7: got state %0d required 3", st1_log[3]); end
      run_line(66, 130);
      n_tests++;
      if (st1_log[2] !== 3'd2 || st1_log[3] !== 3'd0) begin
         n_fail++; $display("FAIL scale_row8: got states %0d %0d required 2 0", st1_log[2], st1_log[3]);
      end
      begin
         int seen = 0;
         for (int x = 1; x < 130; x++) if (dr1_log[x] !== 1'b0) seen++;
         n_tests++;
         if (seen != 0) begin n_fail++; $display("FAIL scale_row8_nodraw: got %0d drawing cycles required 0", seen); end
      end
      $display("[TB] scaled lines checked");
   endtask

   task automatic test_transparency;
      setup(100, 50, 0, 1'b0, 1'b0);
      run_line(50, 130);
      for (int k = 0; k < 8; k++) begin
         n_tests++;
         if (dr0_log[101+k] !== 1'(k % 2) || px0_log[101+k] !== ((k % 2 == 1) ? 3'd5 : 3'd0)) begin
            n_fail++; $display("FAIL transp[%0d]: got drw=%0d pix=%0d required drw=%0d pix=%0d", k, dr0_log[101+k], px0_log[101+k], k % 2, (k % 2 == 1) ? 5 : 0);
         end
      end
      $display("[TB] transparency checked");
   endtask

   task automatic test_clip;
      setup(780, 50, 2, 1'b0, 1'b0);
      run_line(50, 790);
      n_tests++;
      if (st0_log[782] !== 3'd5 || st0_log[783] !== 3'd6 || st0_log[784] !== 3'd0) begin
         n_fail++; $display("FAIL clip_states: got %0d %0d %0d required 5 6 0", st0_log[782], st0_log[783], st0_log[784]);
      end
      n_tests++;
      if (dr0_log[783] !== 1'b1 || dr0_log[784] !== 1'b0) begin
         n_fail++; $display("FAIL clip_drawing: got %0d %0d required 1 0", dr0_log[783], dr0_log[784]);
      end
      $display("[TB] line-end clip checked");
   endtask

   task automatic test_reset_mid;
      int bad = 0;
      setup(100, 50, 2, 1'b0, 1'b0);
      sy = 10'd50;
      step(0, 1'b1);
      for (int x = 1; x < 104; x++) step(x, 1'b0);
      n_tests++;
      if (dr0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got drw=%0d required 1", dr0); end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (pix0 !== 3'd0 || dr0 !== 1'b0 || st0 !== 3'd0) begin
         n_fail++; $display("FAIL rstmid_async: got pix=%0d drw=%0d st=%0d required 0 0 0", pix0, dr0, st0);
      end
      #2 rst = 1'b0;
      for (int x = 104; x < 130; x++) begin
         step(x, 1'b0);
         if (dr0_log[x] !== 1'b0 || st0_log[x] !== 3'd0) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL rstmid_stay_idle: got %0d active cycles required 0", bad); end
      $display("[TB] mid-line reset checked");
   endtask

   task automatic test_enable;
      int bad = 0;
      setup(100, 50, 2, 1'b0, 1'b0);
      en = 1'b0;
      run_line(50, 130);
      for (int x = 1; x < 130; x++)
         if (ad0_log[x] !== 8'd0 || st0_log[x] !== 3'd0 || dr0_log[x] !== 1'b0) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL enable_off: got %0d active cycles required 0", bad); end
      en = 1'b1;
      $display("[TB] disabled line checked");
   endtask

   task automatic test_line_during_draw;
      setup(100, 50, 2, 1'b0, 1'b0);
      sy = 10'd50;
      step(0, 1'b1);
      for (int x = 1; x < 104; x++) step(x, 1'b0);
      step(0, 1'b1);
      step(1, 1'b0);
      n_tests++;
      if (st0_log[1] !== 3'd1 || dr0_log[1] !== 1'b0) begin
         n_fail++; $display("FAIL line_in_draw: got st=%0d drw=%0d required 1 0", st0_log[1], dr0_log[1]);
      end
      for (int x = 2; x < 120; x++) step(x, 1'b0);
      n_tests++;
      if (ad0_log[99] !== 8'd128 || dr0_log[101] !== 1'b1) begin
         n_fail++; $display("FAIL line_in_draw_restart: got addr=%0d drw=%0d required 128 1", ad0_log[99], dr0_log[101]);
      end
      $display("[TB] line during draw checked");
   endtask

   initial begin
      for (int a = 0; a < 256; a++) rom[a] = rv(a);
      test_reset;
      test_basic;
      test_flip;
      test_scale;
      test_transparency;
      test_clip;
      test_reset_mid;
      test_enable;
      test_line_during_draw;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
